// File: rtl/control_loop_sequencer.sv
// Control-loop initiator: ADC sample -> math update -> DAC write -> programmable idle,
// each step a four-phase arm/finished handshake with the corresponding peer.
module control_loop_sequencer #(
  parameter int ADC_WID         = 18,
  parameter int DAC_DATA_WID    = 20,
  parameter int CONSTS_WID      = 48,
  parameter int CYCLE_COUNT_WID = 18,
  parameter int DELAY_WID       = 16
) (
  input  logic                       clk,
  input  logic                       rst_L,
  input  logic                       run,
  input  logic [DELAY_WID-1:0]       dely,
  output logic                       adc_arm,
  input  logic                       adc_finished,
  input  logic [ADC_WID-1:0]         adc_data,
  output logic                       math_arm,
  input  logic                       math_finished,
  output logic [ADC_WID-1:0]         math_measured,
  output logic [CONSTS_WID-1:0]      math_e_prev,
  output logic [CYCLE_COUNT_WID-1:0] math_cycles,
  output logic [DELAY_WID-1:0]       math_dely,
  input  logic [CONSTS_WID-1:0]      math_e_cur,
  input  logic [DAC_DATA_WID-1:0]    math_adjval,
  output logic                       dac_arm,
  input  logic                       dac_finished,
  output logic [DAC_DATA_WID-1:0]    dac_data,
  output logic                       running,
  output logic [31:0]                iter_count
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADC_REQ, S_ADC_REL, S_MATH_REQ, S_MATH_REL,
    S_DAC_REQ, S_DAC_REL, S_DELAY, S_CHECK
  } state_t;

  localparam logic [CYCLE_COUNT_WID-1:0] CYC_MAX = '1;

  state_t                     state, state_nxt;
  logic [CYCLE_COUNT_WID-1:0] cycle_cnt;
  logic [DELAY_WID-1:0]       delay_cnt;
  logic                       first_iter;

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    adc_arm   = 1'b0;
    math_arm  = 1'b0;
    dac_arm   = 1'b0;
    running   = (state != S_IDLE);
    case (state)
      S_IDLE:     if (run) state_nxt = S_ADC_REQ;
      S_ADC_REQ: begin
        adc_arm = 1'b1;
        if (adc_finished) state_nxt = S_ADC_REL;
      end
      S_ADC_REL:  if (!adc_finished) state_nxt = S_MATH_REQ;
      S_MATH_REQ: begin
        math_arm = 1'b1;
        if (math_finished) state_nxt = S_MATH_REL;
      end
      S_MATH_REL: if (!math_finished) state_nxt = S_DAC_REQ;
      S_DAC_REQ: begin
        dac_arm = 1'b1;
        if (dac_finished) state_nxt = S_DAC_REL;
      end
      S_DAC_REL:  if (!dac_finished) state_nxt = (math_dely == '0) ? S_CHECK : S_DELAY;
      S_DELAY:    if (delay_cnt <= DELAY_WID'(1)) state_nxt = S_CHECK;
      S_CHECK:    state_nxt = run ? S_ADC_REQ : S_IDLE;
      default:    state_nxt = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_L) begin
      state         <= S_IDLE;
      cycle_cnt     <= '0;
      delay_cnt     <= '0;
      first_iter    <= 1'b0;
      math_measured <= '0;
      math_e_prev   <= '0;
      math_cycles   <= '0;
      math_dely     <= '0;
      dac_data      <= '0;
      iter_count    <= '0;
    end else begin
      state <= state_nxt;
      if (state != S_IDLE && cycle_cnt != CYC_MAX)
        cycle_cnt <= cycle_cnt + CYCLE_COUNT_WID'(1);
      case (state)
        S_IDLE: if (run) begin
          cycle_cnt   <= '0;
          math_dely   <= dely;
          math_e_prev <= '0;
          first_iter  <= 1'b1;
        end
        S_ADC_REQ: if (adc_finished) begin
          // The first sample after leaving IDLE has no predecessor to measure against.
          math_measured <= adc_data;
          math_cycles   <= first_iter ? '0 : cycle_cnt;
          cycle_cnt     <= CYCLE_COUNT_WID'(1);
          first_iter    <= 1'b0;
        end
        S_MATH_REQ: if (math_finished) begin
          math_e_prev <= math_e_cur;
          dac_data    <= math_adjval;
        end
        S_DAC_REL: if (!dac_finished) begin
          iter_count <= iter_count + 32'd1;
          delay_cnt  <= math_dely;
        end
        S_DELAY: delay_cnt <= delay_cnt - DELAY_WID'(1);
        S_CHECK: if (run) math_dely <= dely;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/control_loop_sequencer.md
Name: control_loop_sequencer

Overview:
- Initiator side of the control-loop math handshake. Each iteration:
  - reads the ADC;
  - arms the math unit with the measurement, previous error, elapsed cycles and delay;
  - captures the new error and adjustment;
  - writes the adjustment to the DAC;
  - waits a programmable delay.
- Sits between the ADC/DAC drivers and the math unit; driven by the kernel-visible run bit and constants.

Parameters:
ADC_WID, 18, ADC sample width (twos-complement)
DAC_DATA_WID, 20, DAC word width
CONSTS_WID, 48, fixed-point error width (8 whole, 40 frac)
CYCLE_COUNT_WID, 18, elapsed-cycle counter width
DELAY_WID, 16, inter-iteration delay width (clock cycles)

Ports:
clk  in  1  system clock
rst_L  in  1  synchronous active-low reset
run  in  1  loop enable
dely  in  DELAY_WID  cycles to idle after each DAC write
adc_arm  out  1  ADC conversion request
adc_finished  in  1  ADC conversion done
adc_data  in  ADC_WID  ADC sample, valid while adc_finished=1
math_arm  out  1  math unit request
math_finished  in  1  math unit done
math_measured  out  ADC_WID  latched sample to math unit
math_e_prev  out  CONSTS_WID  previous error to math unit
math_cycles  out  CYCLE_COUNT_WID  cycles since previous sample
math_dely  out  DELAY_WID  latched dely
math_e_cur  in  CONSTS_WID  new error, valid while math_finished=1
math_adjval  in  DAC_DATA_WID  new DAC value, valid while math_finished=1
dac_arm  out  1  DAC write request
dac_finished  in  1  DAC write done
dac_data  out  DAC_DATA_WID  word to DAC
running  out  1  high from the cycle after leaving IDLE until return to IDLE
iter_count  out  32  completed iterations, wraps at 2^32

Behaviour:
- Clock: the single clock is clk. Reset is synchronous, active-low on rst_L, and sampled on posedge clk.
- Reset values: all outputs are 0; state is IDLE; the cycle counter and e_prev are 0.
- Reset asserted mid-iteration: abort in that cycle and drop all arms. Downstream blocks complete their own four-phase release.
- Handshake (all three peers): four-phase.
  - Raise X_arm.
  - Hold it until X_finished=1 is sampled.
  - Drop X_arm the next cycle.
  - Wait for X_finished=0 before proceeding.
  - X_arm never rises while X_finished=1.
- States and transitions:
  - IDLE: when run=1, clear the cycle counter and latch dely into math_dely. Next state is ADC_REQ.
  - ADC_REQ: adc_arm=1. On adc_finished=1:
    - latch adc_data into math_measured;
    - math_cycles <= cycle counter;
    - cycle counter <= 1;
    - next state is ADC_REL.
  - ADC_REL: adc_arm=0. On adc_finished=0, next state is MATH_REQ.
  - MATH_REQ: math_arm=1. On math_finished=1:
    - math_e_prev <= math_e_cur;
    - dac_data <= math_adjval;
    - next state is MATH_REL.
  - MATH_REL: math_arm=0. On math_finished=0, next state is DAC_REQ.
  - DAC_REQ: dac_arm=1. On dac_finished=1, next state is DAC_REL.
  - DAC_REL: dac_arm=0. On dac_finished=0:
    - iter_count++;
    - if dely=0 go to CHECK, else load the delay counter with math_dely and go to DELAY.
  - DELAY: decrement the counter each cycle. At 1, go to CHECK. Exactly math_dely cycles are spent in DELAY.
  - CHECK: if run=1, latch dely into math_dely and go to ADC_REQ. Otherwise go to IDLE.
- run deassert mid-iteration: the current iteration completes through the DAC write and delay, then goes to IDLE. There is no partial DAC write.
- Cycle counter:
  - Increments every clk while not in IDLE.
  - Saturates at 2^CYCLE_COUNT_WID-1.
  - The first iteration after IDLE presents math_cycles=0 and math_e_prev=0.
- math_measured, math_e_prev, math_cycles and math_dely are stable for the whole time math_arm=1.
- dely changes take effect only at IDLE exit or CHECK.

Test Plan:
- Single iteration:
  - Stimulus: rst_L=1, run=1, dely=0; ADC returns adc_data=18'h00100 after 3 cycles; math returns e_cur=48'h1, adjval=20'h00ABC after 10 cycles.
  - Required response: dac_data=20'h00ABC while dac_arm=1; math_cycles=0 and math_e_prev=0 on the first arm; iter_count=1.
- Second iteration:
  - Stimulus: continue the first scenario with run=1.
  - Required response: math_e_prev=48'h1; math_cycles equals the exact clk count between the two adc_finished rising samples.
- Delay:
  - Stimulus: dely=5.
  - Required response: exactly 5 cycles in DELAY between the DAC_REL exit and the next adc_arm rise (7 cycles including the DAC_REL exit and CHECK).
  - Stimulus: dely=0.
  - Required response: next adc_arm rises 2 cycles after dac_finished falls.
- Stop mid-loop:
  - Stimulus: drop run while math_arm=1.
  - Required response: DAC write still occurs, iter_count increments, FSM returns to IDLE, running=0, no further adc_arm.
- Reset mid-iteration:
  - Stimulus: pull rst_L low for 1 cycle during MATH_REQ.
  - Required response: next cycle all arms=0, dac_data=0, iter_count=0; restart with run=1 shows math_e_prev=0.
- Slow/stuck peers:
  - Stimulus: hold adc_finished=1 for 4 cycles after adc_arm drops.
  - Required response: FSM waits in ADC_REL; math_arm stays 0 until adc_finished=0.
  - Stimulus: force the cycle counter past 2^18.
  - Required response: math_cycles=18'h3FFFF.
